// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM encoding and line field offset helpers.
package cache_pkg;

    localparam int WORD_SIZE      = 32;
    localparam int INDEX_BITS     = 5;
    localparam int BLOCK_OFFSET   = 6;
    localparam int TAG_BITS       = 32 - INDEX_BITS - BLOCK_OFFSET;
    localparam int STATUS_BITS    = 1;
    localparam int WORDS_PER_LINE = (2 ** BLOCK_OFFSET) / 4;
    localparam int LINE_LENGTH    = TAG_BITS + WORDS_PER_LINE * WORD_SIZE + STATUS_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } refill_state_t;

    function automatic int line_tag_lsb(input int line_length, input int tag_bits);
        return line_length - tag_bits;
    endfunction

    function automatic int line_word_lsb(input int k, input int status_bits, input int word_size);
        return status_bits + k * word_size;
    endfunction

endpackage

// File: rtl/cache_refill_if.sv
// Memory read port of the refill engine: one outstanding word request at a time.
interface cache_refill_if #(
    parameter int WORD_SIZE = cache_pkg::WORD_SIZE
) ();
    logic                 mem_rd_req;
    logic [31:0]          mem_addr;
    logic                 mem_rd_ack;
    logic [WORD_SIZE-1:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_addr,
        input  mem_rd_ack,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_addr,
        output mem_rd_ack,
        output mem_rd_data
    );
endinterface

// File: rtl/cache_line_buffer.sv
// Line assembly register: word-indexed write port that also inserts the tag and sets valid.
module cache_line_buffer
    import cache_pkg::*;
#(
    parameter int WORD_SIZE      = cache_pkg::WORD_SIZE,
    parameter int TAG_BITS       = cache_pkg::TAG_BITS,
    parameter int STATUS_BITS    = cache_pkg::STATUS_BITS,
    parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
    parameter int LINE_LENGTH    = cache_pkg::LINE_LENGTH,
    parameter int PTR_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [PTR_W-1:0]       wr_idx,
    input  logic [WORD_SIZE-1:0]   wr_data,
    input  logic [TAG_BITS-1:0]    tag,
    output logic [LINE_LENGTH-1:0] line
);

    logic [LINE_LENGTH-1:0] line_r;

    // Each captured word also refreshes tag and valid, so the old line survives until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r <= {LINE_LENGTH{1'b0}};
        end else if (wr_en) begin
            line_r[line_tag_lsb(LINE_LENGTH, TAG_BITS) +: TAG_BITS]                   <= tag;
            line_r[line_word_lsb(int'(wr_idx), STATUS_BITS, WORD_SIZE) +: WORD_SIZE] <= wr_data;
            line_r[0]                                                                 <= 1'b1;
        end else begin
            line_r <= line_r;
        end
    end

    assign line = line_r;

endmodule

// File: rtl/cache_refill.sv
// Miss-side refill engine: fetches one cache line word by word and writes it as a whole line.
// Optional CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts fetching at the missed word and wraps.
module cache_refill
    import cache_pkg::*;
#(
    parameter int WORD_SIZE      = cache_pkg::WORD_SIZE,
    parameter int INDEX_BITS     = cache_pkg::INDEX_BITS,
    parameter int BLOCK_OFFSET   = cache_pkg::BLOCK_OFFSET,
    parameter int TAG_BITS       = 32 - INDEX_BITS - BLOCK_OFFSET,
    parameter int STATUS_BITS    = cache_pkg::STATUS_BITS,
    parameter int WORDS_PER_LINE = (2 ** BLOCK_OFFSET) / 4,
    parameter int LINE_LENGTH    = TAG_BITS + WORDS_PER_LINE * WORD_SIZE + STATUS_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req,
    input  logic [31:0]            miss_addr,
    output logic                   busy,
    cache_refill_if.master         mem_bus,
    output logic                   line_wr,
    output logic [LINE_LENGTH-1:0] line_out,
    output logic                   crit_valid,
    output logic [WORD_SIZE-1:0]   crit_word,
    output logic                   done
);

    localparam int PTR_W = BLOCK_OFFSET - 2;

    refill_state_t         state_r, state_s;
    logic [TAG_BITS-1:0]   tag_r;
    logic [INDEX_BITS-1:0] index_r;
    logic [PTR_W-1:0]      crit_off_r, word_ptr_r, count_r;
    logic [PTR_W-1:0]      start_ptr_s, ptr_inc_s;
    logic                  capture_s, last_s;
    logic                  busy_r, mem_rd_req_r, line_wr_r, done_r, crit_valid_r;
    logic [31:0]           mem_addr_r;
    logic [WORD_SIZE-1:0]  crit_word_r;
    logic                  unused_s;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign start_ptr_s = miss_addr[BLOCK_OFFSET-1:2];
`else
    assign start_ptr_s = {PTR_W{1'b0}};
`endif

    assign ptr_inc_s = word_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    assign capture_s = (state_r == ST_FETCH) && mem_bus.mem_rd_ack;
    // The counter, not word_ptr, decides completion because word_ptr may start mid-line.
    assign last_s    = capture_s && (count_r == PTR_W'(WORDS_PER_LINE - 1));
    assign unused_s  = ^miss_addr[1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss_req) state_s = ST_FETCH;
                else          state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (last_s) state_s = ST_WRITE;
                else        state_s = ST_FETCH;
            end
            ST_WRITE: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Request latch, word sequencing and registered handshake/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r        <= {TAG_BITS{1'b0}};
            index_r      <= {INDEX_BITS{1'b0}};
            crit_off_r   <= {PTR_W{1'b0}};
            word_ptr_r   <= {PTR_W{1'b0}};
            count_r      <= {PTR_W{1'b0}};
            busy_r       <= 1'b0;
            mem_rd_req_r <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            line_wr_r    <= 1'b0;
            done_r       <= 1'b0;
            crit_valid_r <= 1'b0;
            crit_word_r  <= {WORD_SIZE{1'b0}};
        end else begin
            line_wr_r    <= 1'b0;
            done_r       <= 1'b0;
            crit_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (miss_req) begin
                        tag_r        <= miss_addr[31 -: TAG_BITS];
                        index_r      <= miss_addr[BLOCK_OFFSET +: INDEX_BITS];
                        crit_off_r   <= miss_addr[BLOCK_OFFSET-1:2];
                        word_ptr_r   <= start_ptr_s;
                        count_r      <= {PTR_W{1'b0}};
                        busy_r       <= 1'b1;
                        mem_rd_req_r <= 1'b1;
                        mem_addr_r   <= {miss_addr[31:BLOCK_OFFSET], start_ptr_s, 2'b00};
                    end else begin
                        busy_r       <= 1'b0;
                        mem_rd_req_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (capture_s) begin
                        word_ptr_r <= ptr_inc_s;
                        count_r    <= count_r + {{(PTR_W-1){1'b0}}, 1'b1};
                        mem_addr_r <= {tag_r, index_r, ptr_inc_s, 2'b00};
                        if (word_ptr_r == crit_off_r) begin
                            crit_valid_r <= 1'b1;
                            crit_word_r  <= mem_bus.mem_rd_data;
                        end else begin
                            crit_word_r  <= crit_word_r;
                        end
                        if (last_s) begin
                            mem_rd_req_r <= 1'b0;
                            line_wr_r    <= 1'b1;
                            done_r       <= 1'b1;
                        end else begin
                            mem_rd_req_r <= 1'b1;
                        end
                    end else begin
                        mem_rd_req_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    busy_r       <= 1'b0;
                    mem_rd_req_r <= 1'b0;
                end
                default: begin
                    busy_r       <= 1'b0;
                    mem_rd_req_r <= 1'b0;
                end
            endcase
        end
    end

    cache_line_buffer #(
        .WORD_SIZE      (WORD_SIZE),
        .TAG_BITS       (TAG_BITS),
        .STATUS_BITS    (STATUS_BITS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINE_LENGTH    (LINE_LENGTH),
        .PTR_W          (PTR_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture_s),
        .wr_idx  (word_ptr_r),
        .wr_data (mem_bus.mem_rd_data),
        .tag     (tag_r),
        .line    (line_out)
    );

    assign busy               = busy_r;
    assign mem_bus.mem_rd_req = mem_rd_req_r;
    assign mem_bus.mem_addr   = mem_addr_r;
    assign line_wr            = line_wr_r;
    assign done               = done_r;
    assign crit_valid         = crit_valid_r;
    assign crit_word          = crit_word_r;

endmodule
